// File: rtl/mem_unit_pkg.sv
// Shared constants, data/address types and the transaction opcode
// used by the memory unit and its verification environment.
package pack;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DEPTH  = 16;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        READ  = 2'd0,
        WRITE = 2'd1,
        IDLE  = 2'd2
    } op_t;

endpackage

// File: rtl/mem_unit_intf.sv
// Signal bundle between the memory unit and its environment;
// mod1 is the device-side view.
interface intf;
    import pack::*;

    logic  CLK;
    logic  RST;
    logic  EN;
    logic  WR_EN;
    addr_t ADDR;
    data_t DATA_IN;
    data_t DATA_OUT;
    logic  VALID_OUT;
    logic  ERR;

    modport mod1 (
        input  CLK,
        input  RST,
        input  EN,
        input  WR_EN,
        input  ADDR,
        input  DATA_IN,
        output DATA_OUT,
        output VALID_OUT,
        output ERR
    );

endinterface

// File: rtl/mem_unit.sv
// Single-port synchronous RAM: one access per cycle, registered read data
// with a valid flag, and a one-cycle error pulse for out-of-range addresses.
module mem_unit #(
    parameter int unsigned DATA_W = pack::DATA_W,
    parameter int unsigned ADDR_W = pack::ADDR_W,
    parameter int unsigned DEPTH  = pack::DEPTH
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              WR_EN,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] DATA_IN,
    output logic [DATA_W-1:0] DATA_OUT,
    output logic              VALID_OUT,
    output logic              ERR
);

    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              in_range;
    logic              do_write;

    assign in_range = ({1'b0, ADDR} < DEPTH_L);
    assign do_write = EN && WR_EN && in_range;

    always_comb begin
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (EN) begin
            if (!in_range) begin
                err_d = 1'b1;
                if (!WR_EN) begin
                    data_d = '0;
                end
            end else if (!WR_EN) begin
                data_d  = mem_q[ADDR];
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mem_q   <= '{default: '0};
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (do_write) begin
                mem_q[ADDR] <= DATA_IN;
            end
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign DATA_OUT  = data_q;
    assign VALID_OUT = valid_q;
    assign ERR       = err_q;

endmodule

// File: tb/tb_mem_unit.sv
// Directed bench for mem_unit: a full-depth instance and a DEPTH=12
// instance share the same stimulus.
module tb_mem_unit;

    logic        CLK;
    logic        RST;
    logic        EN;
    logic        WR_EN;
    logic [3:0]  ADDR;
    logic [31:0] DATA_IN;

    logic [31:0] dout16, dout12;
    logic        v16, v12, e16, e12;

    int checks = 0;
    int errors = 0;

    mem_unit u_dut (
        .CLK(CLK), .RST(RST), .EN(EN), .WR_EN(WR_EN), .ADDR(ADDR),
        .DATA_IN(DATA_IN), .DATA_OUT(dout16), .VALID_OUT(v16), .ERR(e16)
    );

    mem_unit #(.DEPTH(12)) u_dut12 (
        .CLK(CLK), .RST(RST), .EN(EN), .WR_EN(WR_EN), .ADDR(ADDR),
        .DATA_IN(DATA_IN), .DATA_OUT(dout12), .VALID_OUT(v12), .ERR(e12)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        en;
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] din;
        logic [31:0] dout;
        logic        valid;
        logic        err;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one access and return 1 ns after the edge that consumes it.
    task automatic access(input logic en, input logic wr, input logic [3:0] a, input logic [31:0] d);
        EN      = en;
        WR_EN   = wr;
        ADDR    = a;
        DATA_IN = d;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b0; EN = 1'b0; WR_EN = 1'b0; ADDR = '0; DATA_IN = '0;

        tv.push_back('{1'b1, 1'b1, 4'd5, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0});
        tv.push_back('{1'b1, 1'b0, 4'd5, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0});
        tv.push_back('{1'b0, 1'b0, 4'd5, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0});
        tv.push_back('{1'b1, 1'b1, 4'd2, 32'h000000A5, 32'hDEADBEEF, 1'b0, 1'b0});
        tv.push_back('{1'b1, 1'b0, 4'd2, 32'h0,        32'h000000A5, 1'b1, 1'b0});
        tv.push_back('{1'b0, 1'b1, 4'd2, 32'h12345678, 32'h000000A5, 1'b0, 1'b0});
        tv.push_back('{1'b0, 1'b0, 4'd2, 32'h0,        32'h000000A5, 1'b0, 1'b0});
        tv.push_back('{1'b0, 1'b1, 4'd5, 32'hFFFFFFFF, 32'h000000A5, 1'b0, 1'b0});
        tv.push_back('{1'b1, 1'b0, 4'd2, 32'h0,        32'h000000A5, 1'b1, 1'b0});
        tv.push_back('{1'b1, 1'b0, 4'd5, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0});
        tv.push_back('{1'b1, 1'b1, 4'd7, 32'h00000001, 32'hDEADBEEF, 1'b0, 1'b0});
        tv.push_back('{1'b1, 1'b1, 4'd7, 32'h00000002, 32'hDEADBEEF, 1'b0, 1'b0});
        tv.push_back('{1'b1, 1'b0, 4'd7, 32'h0,        32'h00000002, 1'b1, 1'b0});
        tv.push_back('{1'b1, 1'b0, 4'd3, 32'h0,        32'h00000000, 1'b1, 1'b0});

        #12;
        chk("reset_dout16", dout16, 32'h0);
        chk("reset_valid16", {31'b0, v16}, 32'h0);
        chk("reset_err16", {31'b0, e16}, 32'h0);
        chk("reset_dout12", dout12, 32'h0);
        RST = 1'b1;

        foreach (tv[i]) begin
            access(tv[i].en, tv[i].wr, tv[i].addr, tv[i].din);
            chk($sformatf("vec%0d_dout", i), dout16, tv[i].dout);
            chk($sformatf("vec%0d_valid", i), {31'b0, v16}, {31'b0, tv[i].valid});
            chk($sformatf("vec%0d_err", i), {31'b0, e16}, {31'b0, tv[i].err});
        end

        for (int i = 0; i < 16; i++) begin
            access(1'b1, 1'b1, 4'(i), 32'(i) * 32'h11111111);
            chk($sformatf("sweep_wr%0d_valid", i), {31'b0, v16}, 32'h0);
            chk($sformatf("sweep_wr%0d_err12", i), {31'b0, e12}, (i >= 12) ? 32'h1 : 32'h0);
        end
        for (int i = 0; i < 16; i++) begin
            access(1'b1, 1'b0, 4'(i), 32'h0);
            chk($sformatf("sweep_rd%0d_dout", i), dout16, 32'(i) * 32'h11111111);
            chk($sformatf("sweep_rd%0d_valid", i), {31'b0, v16}, 32'h1);
            chk($sformatf("sweep_rd%0d_dout12", i), dout12, (i < 12) ? 32'(i) * 32'h11111111 : 32'h0);
            chk($sformatf("sweep_rd%0d_valid12", i), {31'b0, v12}, (i < 12) ? 32'h1 : 32'h0);
            chk($sformatf("sweep_rd%0d_err12", i), {31'b0, e12}, (i >= 12) ? 32'h1 : 32'h0);
        end

        // Out-of-range write holds DATA_OUT; out-of-range read zeroes it.
        access(1'b1, 1'b0, 4'd4, 32'h0);
        chk("oor_pre_dout12", dout12, 32'h44444444);
        access(1'b1, 1'b1, 4'd13, 32'hCAFEF00D);
        chk("oor_wr_err12", {31'b0, e12}, 32'h1);
        chk("oor_wr_valid12", {31'b0, v12}, 32'h0);
        chk("oor_wr_dout12", dout12, 32'h44444444);
        access(1'b1, 1'b0, 4'd13, 32'h0);
        chk("oor_rd_err12", {31'b0, e12}, 32'h1);
        chk("oor_rd_valid12", {31'b0, v12}, 32'h0);
        chk("oor_rd_dout12", dout12, 32'h0);
        chk("inrange_rd13_dout16", dout16, 32'hCAFEF00D);
        access(1'b0, 1'b0, 4'd13, 32'h0);
        chk("oor_err_pulse12", {31'b0, e12}, 32'h0);
        for (int i = 0; i < 12; i++) begin
            access(1'b1, 1'b0, 4'(i), 32'h0);
            chk($sformatf("oor_keep%0d_dout12", i), dout12, 32'(i) * 32'h11111111);
        end

        // Mid-cycle reset pulse right after a valid read.
        access(1'b1, 1'b0, 4'd3, 32'h0);
        chk("pre_rst_valid", {31'b0, v16}, 32'h1);
        EN = 1'b0;
        RST = 1'b0;
        #1;
        chk("midrst_dout16", dout16, 32'h0);
        chk("midrst_valid16", {31'b0, v16}, 32'h0);
        chk("midrst_err16", {31'b0, e16}, 32'h0);
        RST = 1'b1;
        #1;
        access(1'b1, 1'b0, 4'd3, 32'h0);
        chk("postrst_rd3_dout", dout16, 32'h0);
        chk("postrst_rd3_valid", {31'b0, v16}, 32'h1);
        access(1'b1, 1'b0, 4'd15, 32'h0);
        chk("postrst_rd15_dout", dout16, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
